// File: rtl/slave_in_port_rx.sv
// slave_in_port_rx: serial-bus slave receive front end.
// Deserialises a 12-bit address (rx_address) and 8-bit write bytes (rx_data),
// both MSB first, and latches the master's read/write command.
// Define SLAVE_IN_BURST_EN to let a write stream further bytes after the first;
// without it every write ends after one byte and m_valid must drop to re-arm.
module slave_in_port_rx #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_address,
  input  logic                   rx_data,
  input  logic                   m_valid,
  input  logic                   read_enable,
  input  logic                   write_enable,
  input  logic                   s_valid,
  input  logic                   m_ready,
  output logic                   rx_done,
  output logic                   read_en_in,
  output logic                   write_en_in,
  output logic                   read_en_in1,
  output logic                   write_en_in1,
  output logic                   s_ready,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic [DATA_WIDTH-1:0]  data,
  output logic [BURST_WIDTH-1:0] burst_counter,
  output logic [7:0]             address_counter,
  output logic [3:0]             data_counter
);

  typedef enum logic [1:0] {IDLE, ADDR, BURST, RDWAIT} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  address_q, address_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [7:0]             addr_cnt_q, addr_cnt_d;
  logic [3:0]             data_cnt_q, data_cnt_d;
  logic                   rd_q, rd_d, wr_q, wr_d;
  logic                   rx_done_q, rx_done_d;
  logic                   rd1_q, rd1_d, wr1_q, wr1_d;
  logic                   s_ready_q, s_ready_d;
  // Blocks restarts until m_valid has dropped after a single-byte write.
  logic                   hold_off_q, hold_off_d;
  logic                   go_idle;
  logic                   write_start;

  // Next-state and output computation for the receive FSM.
  // NOTE: every variable gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    data_d      = data_q;
    burst_d     = burst_q;
    addr_cnt_d  = addr_cnt_q;
    data_cnt_d  = data_cnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    s_ready_d   = s_ready_q;
    hold_off_d  = hold_off_q;
    rx_done_d   = 1'b0;
    rd1_d       = 1'b0;
    wr1_d       = 1'b0;
    go_idle     = 1'b0;
    write_start = write_enable & ~read_enable;

    case (state_q)
      IDLE: begin
        if (!m_valid) hold_off_d = 1'b0;
        if (m_valid && s_ready_q && !hold_off_q) begin
          // Read wins when both commands arrive together.
          rd_d       = read_enable;
          wr_d       = write_start;
          address_d  = {address_q[ADDR_WIDTH-2:0], rx_address};
          addr_cnt_d = 8'd1;
          if (write_start) begin
            data_d     = {data_q[DATA_WIDTH-2:0], rx_data};
            data_cnt_d = 4'd1;
          end
          s_ready_d = 1'b0;
          state_d   = ADDR;
        end
      end

      ADDR: begin
        if (!m_valid) begin
          go_idle = 1'b1;
        end else begin
          address_d  = {address_q[ADDR_WIDTH-2:0], rx_address};
          addr_cnt_d = addr_cnt_q + 8'd1;
          if (wr_q && data_cnt_q < 4'(DATA_WIDTH)) begin
            data_d     = {data_q[DATA_WIDTH-2:0], rx_data};
            data_cnt_d = data_cnt_q + 4'd1;
          end
          if (addr_cnt_q == 8'(ADDR_WIDTH - 1)) begin
            rx_done_d = 1'b1;
            if (wr_q) begin
              wr1_d = 1'b1;
`ifdef SLAVE_IN_BURST_EN
              burst_d    = burst_q + 1'b1;
              data_cnt_d = 4'd0;
              state_d    = BURST;
`else
              go_idle    = 1'b1;
              hold_off_d = 1'b1;
`endif
            end else begin
              rd1_d   = 1'b1;
              state_d = RDWAIT;
            end
          end
        end
      end

`ifdef SLAVE_IN_BURST_EN
      BURST: begin
        if (!m_valid) begin
          go_idle = 1'b1;
        end else begin
          data_d = {data_q[DATA_WIDTH-2:0], rx_data};
          if (data_cnt_q == 4'(DATA_WIDTH - 1)) begin
            rx_done_d  = 1'b1;
            wr1_d      = 1'b1;
            address_d  = address_q + 1'b1;
            burst_d    = burst_q + 1'b1;
            data_cnt_d = 4'd0;
          end else begin
            data_cnt_d = data_cnt_q + 4'd1;
          end
        end
      end
`endif

      RDWAIT: begin
        if (s_valid && m_ready) go_idle = 1'b1;
      end

      default: go_idle = 1'b1;
    endcase

    // Common return to IDLE: counters and command latches cleared, slave ready.
    if (go_idle) begin
      state_d    = IDLE;
      s_ready_d  = 1'b1;
      addr_cnt_d = 8'd0;
      data_cnt_d = 4'd0;
      burst_d    = '0;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      address_q  <= '0;
      data_q     <= '0;
      burst_q    <= '0;
      addr_cnt_q <= 8'd0;
      data_cnt_q <= 4'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rx_done_q  <= 1'b0;
      rd1_q      <= 1'b0;
      wr1_q      <= 1'b0;
      s_ready_q  <= 1'b1;
      hold_off_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      data_q     <= data_d;
      burst_q    <= burst_d;
      addr_cnt_q <= addr_cnt_d;
      data_cnt_q <= data_cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rx_done_q  <= rx_done_d;
      rd1_q      <= rd1_d;
      wr1_q      <= wr1_d;
      s_ready_q  <= s_ready_d;
      hold_off_q <= hold_off_d;
    end
  end

  assign rx_done         = rx_done_q;
  assign read_en_in      = rd_q;
  assign write_en_in     = wr_q;
  assign read_en_in1     = rd1_q;
  assign write_en_in1    = wr1_q;
  assign s_ready         = s_ready_q;
  assign address         = address_q;
  assign data            = data_q;
  assign burst_counter   = burst_q;
  assign address_counter = addr_cnt_q;
  assign data_counter    = data_cnt_q;

endmodule

// File: tb/tb_slave_in_port_rx.sv
// Self-checking bench for slave_in_port_rx: directed and randomized transfers
// compared against a bit-stream model of the serial protocol.
module tb_slave_in_port_rx;

  logic        clk = 1'b0;
  logic        rst, rx_address, rx_data, m_valid, read_enable, write_enable;
  logic        s_valid, m_ready;
  logic        rx_done, read_en_in, write_en_in, read_en_in1, write_en_in1, s_ready;
  logic [11:0] address;
  logic [7:0]  data;
  logic [11:0] burst_counter;
  logic [7:0]  address_counter;
  logic [3:0]  data_counter;

  int total = 0;
  int bad   = 0;

`ifdef SLAVE_IN_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  slave_in_port_rx dut (
    .clk(clk), .rst(rst), .rx_address(rx_address), .rx_data(rx_data),
    .m_valid(m_valid), .read_enable(read_enable), .write_enable(write_enable),
    .s_valid(s_valid), .m_ready(m_ready), .rx_done(rx_done),
    .read_en_in(read_en_in), .write_en_in(write_en_in),
    .read_en_in1(read_en_in1), .write_en_in1(write_en_in1), .s_ready(s_ready),
    .address(address), .data(data), .burst_counter(burst_counter),
    .address_counter(address_counter), .data_counter(data_counter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    rx_address = 1'b0; rx_data = 1'b0; m_valid = 1'b0;
    read_enable = 1'b0; write_enable = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".rx_done"},   32'(rx_done), 0);
    chk({tag, ".rd_in"},     32'(read_en_in), 0);
    chk({tag, ".wr_in"},     32'(write_en_in), 0);
    chk({tag, ".rd_in1"},    32'(read_en_in1), 0);
    chk({tag, ".wr_in1"},    32'(write_en_in1), 0);
    chk({tag, ".s_ready"},   32'(s_ready), 1);
    chk({tag, ".address"},   32'(address), 0);
    chk({tag, ".data"},      32'(data), 0);
    chk({tag, ".burst"},     32'(burst_counter), 0);
    chk({tag, ".addr_cnt"},  32'(address_counter), 0);
    chk({tag, ".data_cnt"},  32'(data_counter), 0);
  endtask

  // Write transfer. The model sees the rx_data line as one bit stream:
  // byte 0 in bits 0..7, four don't-care bits while the address finishes,
  // then burst byte j in bits 12+8(j-1) .. 19+8(j-1). Byte j completes
  // (rx_done visible) after edge 11+8j.
  task automatic do_write(input logic [11:0] addr, input int nbytes,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0]  bq[3];
    logic [11:0] ea;
    int          nb, last, j;
    bit          exp_done;
    bq[0] = b0; bq[1] = b1; bq[2] = b2;
    nb   = BURST_ON ? nbytes : 1;
    last = 11 + 8 * (nb - 1);
    for (int k = 0; k <= last; k++) begin
      m_valid      = 1'b1;
      write_enable = (k == 0) ? 1'b1 : 1'($urandom);
      read_enable  = (k == 0) ? 1'b0 : 1'($urandom);
      rx_address   = (k < 12) ? addr[11-k] : 1'($urandom);
      if (k < 8)       rx_data = bq[0][7-k];
      else if (k < 12) rx_data = 1'($urandom);
      else             rx_data = bq[(k-12)/8 + 1][7 - (k-12)%8];
      s_valid = 1'($urandom);
      m_ready = 1'($urandom);
      tick();
      exp_done = (k >= 11) && ((k - 11) % 8 == 0);
      chk("wr.rx_done", 32'(rx_done), 32'(exp_done));
      chk("wr.wr_in1", 32'(write_en_in1), 32'(exp_done));
      if (exp_done) begin
        j  = (k - 11) / 8;
        ea = addr + 12'(j);
        chk("wr.address", 32'(address), 32'(ea));
        chk("wr.data",    32'(data), 32'(bq[j]));
        chk("wr.rd_in1",  32'(read_en_in1), 0);
        chk("wr.burst",   32'(burst_counter), BURST_ON ? 32'(j + 1) : 0);
      end
      if (k == 0) begin
        chk("wr.start_s_ready", 32'(s_ready), 0);
        chk("wr.start_wr_in",   32'(write_en_in), 1);
        chk("wr.start_rd_in",   32'(read_en_in), 0);
      end
    end
    if (!BURST_ON) begin
      // m_valid still high: no new transaction until it drops.
      for (int h = 0; h < 3; h++) begin
        m_valid = 1'b1; write_enable = 1'b1;
        rx_address = 1'($urandom); rx_data = 1'($urandom);
        tick();
        chk("wr.hold_addr_cnt", 32'(address_counter), 0);
        chk("wr.hold_rx_done",  32'(rx_done), 0);
        chk("wr.hold_s_ready",  32'(s_ready), 1);
      end
    end
    quiet_inputs();
    tick();
    chk("wr.end_s_ready",  32'(s_ready), 1);
    chk("wr.end_wr_in",    32'(write_en_in), 0);
    chk("wr.end_addr_cnt", 32'(address_counter), 0);
    chk("wr.end_data_cnt", 32'(data_counter), 0);
    chk("wr.end_burst",    32'(burst_counter), 0);
  endtask

  // Read transfer: both commands raised at start (read must win), then a wait
  // with no handshake, then s_valid & m_ready together.
  task automatic do_read(input logic [11:0] addr, input int wait_n);
    int r;
    for (int k = 0; k < 12; k++) begin
      m_valid      = 1'b1;
      read_enable  = (k == 0) ? 1'b1 : 1'($urandom);
      write_enable = (k == 0) ? 1'b1 : 1'($urandom);
      rx_address   = addr[11-k];
      rx_data      = 1'($urandom);
      s_valid      = 1'($urandom);
      m_ready      = 1'($urandom);
      tick();
      chk("rd.rx_done", 32'(rx_done), 32'(k == 11));
      chk("rd.rd_in1",  32'(read_en_in1), 32'(k == 11));
      chk("rd.wr_in1",  32'(write_en_in1), 0);
      if (k == 0) begin
        chk("rd.start_rd_in", 32'(read_en_in), 1);
        chk("rd.start_wr_in", 32'(write_en_in), 0);
      end
      if (k == 11) chk("rd.address", 32'(address), 32'(addr));
    end
    for (int w = 0; w < wait_n; w++) begin
      r = int'($urandom_range(0, 2));
      s_valid = (r == 1);
      m_ready = (r == 2);
      rx_address = 1'($urandom); rx_data = 1'($urandom);
      tick();
      chk("rd.wait_s_ready", 32'(s_ready), 0);
      chk("rd.wait_rx_done", 32'(rx_done), 0);
      chk("rd.wait_rd_in",   32'(read_en_in), 1);
    end
    quiet_inputs();
    s_valid = 1'b1; m_ready = 1'b1;
    tick();
    chk("rd.end_s_ready", 32'(s_ready), 1);
    chk("rd.end_rd_in",   32'(read_en_in), 0);
    quiet_inputs();
  endtask

  // Abort a write after nbits address bits by dropping m_valid.
  task automatic do_abort(input logic [11:0] addr, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      m_valid = 1'b1; write_enable = (k == 0);
      rx_address = addr[11-k]; rx_data = 1'($urandom);
      tick();
      chk("ab.rx_done", 32'(rx_done), 0);
      chk("ab.addr_cnt", 32'(address_counter), 32'(k + 1));
    end
    quiet_inputs();
    tick();
    chk("ab.s_ready",  32'(s_ready), 1);
    chk("ab.addr_cnt", 32'(address_counter), 0);
    chk("ab.data_cnt", 32'(data_counter), 0);
    chk("ab.wr_in",    32'(write_en_in), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("ab.idle_rx_done", 32'(rx_done), 0);
    end
  endtask

  initial begin
    quiet_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_valid = 1'($urandom); rx_address = 1'($urandom); rx_data = 1'($urandom);
      write_enable = 1'($urandom); read_enable = 1'($urandom);
      tick();
    end
    check_reset_values("rst");
    quiet_inputs();
    rst = 1'b0;
    tick();
    check_reset_values("post_rst");

    do_write(12'hA5C, 3, 8'hB3, 8'h11, 8'h22);
    do_read(12'h001, 4);
    do_abort(12'h3C7, 5);
    do_write(12'hFFF, 2, 8'h5A, 8'hC4, 8'h00);

    for (int t = 0; t < 8; t++) begin
      if (1'($urandom))
        do_write(12'($urandom), int'($urandom_range(1, 3)),
                 8'($urandom), 8'($urandom), 8'($urandom));
      else
        do_read(12'($urandom), int'($urandom_range(0, 6)));
    end

    // Reset in the middle of an address phase.
    for (int k = 0; k < 4; k++) begin
      m_valid = 1'b1; write_enable = 1'b1;
      rx_address = 1'b1; rx_data = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    check_reset_values("mid_rst");
    rst = 1'b0;
    quiet_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
